// File: rtl/aes_pkg.sv
// Shared definitions for the AES datapath blocks.
//   AES_BLOCK_W      : AES state / round-key width in bits
//   AES128_NUM_KEYS  : number of round keys for AES-128 (initial key + 10 rounds)
//   ark_state_t      : control states of the AddRoundKey engine
//   ark_cnt_w()      : width of a counter that spans 0..beats-1, never below 1 bit
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES128_NUM_KEYS = 11;

    typedef enum logic [1:0] {
        ARK_IDLE,
        ARK_RUN,
        ARK_DONE
    } ark_state_t;

    function automatic int ark_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/round_key_bank.sv
// Round-key storage: NUM_KEYS x BLOCK_W registers, one write port and one
// combinational read port. Reads of a slot index >= NUM_KEYS return zero and
// raise rd_bad; writes to such an index are dropped.
//   clk, rst_n : clock, asynchronous active-low reset (clears every slot)
//   wr_en      : write wr_data into slot wr_idx at the next rising edge
//   wr_idx     : write slot
//   wr_data    : key to store
//   rd_idx     : read slot
//   rd_data    : key in slot rd_idx (zero when out of range)
//   rd_bad     : rd_idx >= NUM_KEYS
module round_key_bank
    import aes_pkg::*;
#(
    parameter int BLOCK_W  = AES_BLOCK_W,
    parameter int NUM_KEYS = AES128_NUM_KEYS,
    parameter int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [BLOCK_W-1:0] rd_data,
    output logic               rd_bad
);

    // One extra bit so the limit is representable even when NUM_KEYS is a
    // power of two.
    localparam logic [IDX_W:0] NK = (IDX_W + 1)'(NUM_KEYS);

    logic [BLOCK_W-1:0] keys [NUM_KEYS];
    logic               wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_idx} < NK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                keys[i] <= '0;
            end
        end else if (wr_ok) begin
            keys[wr_idx] <= wr_data;
        end
    end

    assign rd_bad  = !({1'b0, rd_idx} < NK);
    assign rd_data = rd_bad ? '0 : keys[rd_idx];

endmodule

// File: rtl/add_round_key_engine.sv
// Serialised AddRoundKey stage with an internal round-key bank.
// A block is accepted together with a round index; the selected key is
// snapshotted at accept so later key writes cannot disturb the block in
// flight. The block is then XORed LANE_W bits per cycle (lane 0 = LSBs) and
// returned over a valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_wr_en    : write key_wr_data into slot key_wr_idx
//   key_wr_idx   : key slot (indices >= NUM_KEYS are ignored)
//   key_wr_data  : round key
//   in_valid     : input block valid
//   in_ready     : engine idle and able to accept
//   in_data      : state block
//   in_round     : key slot to apply
//   out_valid    : result valid
//   out_ready    : downstream accepts result
//   out_data     : in_data ^ key[in_round]
//   out_round    : in_round echoed
//   out_err      : in_round was out of range (result is in_data unchanged)
module add_round_key_engine
    import aes_pkg::*;
#(
    parameter  int BLOCK_W  = AES_BLOCK_W,
    parameter  int LANE_W   = 32,
    parameter  int NUM_KEYS = AES128_NUM_KEYS,
    localparam int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_wr_en,
    input  logic [IDX_W-1:0]   key_wr_idx,
    input  logic [BLOCK_W-1:0] key_wr_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [IDX_W-1:0]   in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [IDX_W-1:0]   out_round,
    output logic               out_err
);

    localparam int                BEATS  = BLOCK_W / LANE_W;
    localparam int                BEAT_W = ark_cnt_w(BEATS);
    localparam logic [BEAT_W-1:0] LAST   = BEAT_W'(BEATS - 1);

    ark_state_t         state, state_nx;
    logic [BEAT_W-1:0]  beat;
    logic [BLOCK_W-1:0] work_blk;
    logic [BLOCK_W-1:0] key_snap;
    logic [IDX_W-1:0]   work_round;
    logic               work_err;
    logic [BLOCK_W-1:0] bank_key;
    logic               bank_bad;
    logic               accept;

    function automatic logic [BLOCK_W-1:0] lane_xor(
        input logic [BLOCK_W-1:0] blk,
        input logic [BLOCK_W-1:0] key,
        input logic [BEAT_W-1:0]  idx
    );
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[idx*LANE_W +: LANE_W] = blk[idx*LANE_W +: LANE_W] ^ key[idx*LANE_W +: LANE_W];
        return res;
    endfunction

    // The read port looks at in_round combinationally, so a same-cycle
    // write to that slot lands after the snapshot is taken: the accept
    // sees the old key.
    round_key_bank #(
        .BLOCK_W  (BLOCK_W),
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (key_wr_en),
        .wr_idx  (key_wr_idx),
        .wr_data (key_wr_data),
        .rd_idx  (in_round),
        .rd_data (bank_key),
        .rd_bad  (bank_bad)
    );

    assign accept = (state == ARK_IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARK_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ARK_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ARK_RUN;
            end
            ARK_RUN: begin
                if (beat == LAST) state_nx = ARK_DONE;
            end
            ARK_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ARK_IDLE;
            end
            default: state_nx = ARK_IDLE;
        endcase
    end

    // Working registers only change on accept or during RUN, which keeps
    // the result stable for the whole of DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat       <= '0;
            work_blk   <= '0;
            key_snap   <= '0;
            work_round <= '0;
            work_err   <= 1'b0;
        end else if (accept) begin
            beat       <= '0;
            work_blk   <= in_data;
            key_snap   <= bank_key;
            work_round <= in_round;
            work_err   <= bank_bad;
        end else if (state == ARK_RUN) begin
            work_blk <= lane_xor(work_blk, key_snap, beat);
            // Hold on the final lane instead of wrapping; accept clears it.
            if (beat != LAST) beat <= beat + 1'b1;
        end
    end

    assign out_data  = work_blk;
    assign out_round = work_round;
    assign out_err   = work_err;

endmodule

// File: tb/tb_add_round_key_engine.sv
// Bench for add_round_key_engine: three instances (LANE_W 32, 128, 8) share
// the key-write and data inputs; each has its own in_valid. Expected results
// are queued at accept time from a plain key-array model and checked by a
// per-instance monitor whenever out_valid is high.
module tb_add_round_key_engine;
    import aes_pkg::*;

    localparam int NK = AES128_NUM_KEYS;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h00102030405060708090a0b0c0d0e0f0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         kwe = 1'b0;
    logic [3:0]   kidx = '0;
    logic [127:0] kdata = '0;
    logic [127:0] idata = '0;
    logic [3:0]   iround = '0;
    logic         out_ready = 1'b1;
    logic         ordy_cmd = 1'b1;
    bit           bp_mode = 1'b0;
    logic         iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic         ir0, ir1, ir2, ov0, ov1, ov2, oe0, oe1, oe2;
    logic [127:0] od0, od1, od2;
    logic [3:0]   or0, or1, or2;
    logic         pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
    logic [127:0] last_od0 = '0, last_od1 = '0, last_od2 = '0;
    logic [3:0]   last_or0 = '0;
    logic         last_oe0 = 1'b0;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   r;
        logic         e;
        int           acc;
    } exp_t;

    exp_t         q0[$], q1[$], q2[$];
    logic [127:0] ref_key [NK];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready has a single driver: random when bp_mode, otherwise ordy_cmd.
    always @(posedge clk) begin
        #2;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ordy_cmd;
    end

    add_round_key_engine #(.LANE_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .key_wr_en(kwe), .key_wr_idx(kidx), .key_wr_data(kdata),
        .in_valid(iv0), .in_ready(ir0), .in_data(idata), .in_round(iround),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_round(or0), .out_err(oe0));
    add_round_key_engine #(.LANE_W(128)) u128 (
        .clk(clk), .rst_n(rst_n), .key_wr_en(kwe), .key_wr_idx(kidx), .key_wr_data(kdata),
        .in_valid(iv1), .in_ready(ir1), .in_data(idata), .in_round(iround),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_round(or1), .out_err(oe1));
    add_round_key_engine #(.LANE_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .key_wr_en(kwe), .key_wr_idx(kidx), .key_wr_data(kdata),
        .in_valid(iv2), .in_ready(ir2), .in_data(idata), .in_round(iround),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_round(or2), .out_err(oe2));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spur(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: out_valid with no block outstanding", nm);
    endtask

    task automatic mon(input string nm, input exp_t e, input logic [127:0] d, input logic [3:0] r,
                       input logic er, input bit rise, input int lat);
        chk({nm, " data"}, d, e.d);
        chk({nm, " round"}, 128'(r), 128'(e.r));
        chk({nm, " err"}, 128'(er), 128'(e.e));
        if (rise) chk({nm, " latency"}, 128'(cyc - e.acc), 128'(lat));
    endtask

    always @(negedge clk) begin
        if (rst_n && ov0) begin
            if (q0.size() == 0) spur("u32");
            else begin
                mon("u32", q0[0], od0, or0, oe0, !pv0, 4);
                if (out_ready) begin
                    void'(q0.pop_front());
                    last_od0 <= od0; last_or0 <= or0; last_oe0 <= oe0;
                end
            end
        end
        pv0 <= ov0;
    end

    always @(negedge clk) begin
        if (rst_n && ov1) begin
            if (q1.size() == 0) spur("u128");
            else begin
                mon("u128", q1[0], od1, or1, oe1, !pv1, 1);
                if (out_ready) begin void'(q1.pop_front()); last_od1 <= od1; end
            end
        end
        pv1 <= ov1;
    end

    always @(negedge clk) begin
        if (rst_n && ov2) begin
            if (q2.size() == 0) spur("u8");
            else begin
                mon("u8", q2[0], od2, or2, oe2, !pv2, 16);
                if (out_ready) begin void'(q2.pop_front()); last_od2 <= od2; end
            end
        end
        pv2 <= ov2;
    end

    function automatic logic rdy(input int s);
        case (s)
            0: return ir0;
            1: return ir1;
            default: return ir2;
        endcase
    endfunction

    task automatic set_iv(input int s, input logic v);
        case (s)
            0: iv0 = v;
            1: iv1 = v;
            default: iv2 = v;
        endcase
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+1. Optionally writes a key in the accept cycle.
    task automatic send(input int s, input logic [127:0] d, input logic [3:0] r,
                        input bit we = 1'b0, input logic [3:0] wi = '0, input logic [127:0] wd = '0);
        int   n;
        exp_t e;
        n = 0;
        while (!rdy(s) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!rdy(s)) begin
            chk("in_ready timeout", 128'(rdy(s)), 128'(1));
            return;
        end
        idata = d; iround = r; kwe = we; kidx = wi; kdata = wd;
        set_iv(s, 1'b1);
        @(posedge clk); #1;
        e.d   = d ^ ((r < NK) ? ref_key[r] : 128'h0);
        e.r   = r;
        e.e   = (r >= NK);
        e.acc = cyc;
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        if (we && wi < NK) ref_key[wi] = wd;
        set_iv(s, 1'b0);
        kwe = 1'b0;
    endtask

    task automatic key_write(input logic [3:0] i, input logic [127:0] d);
        kwe = 1'b1; kidx = i; kdata = d;
        @(posedge clk); #1;
        if (i < NK) ref_key[i] = d;
        kwe = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain timeout", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
    endtask

    task automatic clear_model();
        for (int i = 0; i < NK; i++) ref_key[i] = '0;
        q0.delete(); q1.delete(); q2.delete();
    endtask

    initial begin
        logic [127:0] k, d;
        int n;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(ir0), 128'(1));
        chk("reset out_valid", 128'(ov0), 128'(0));
        chk("reset out_data", od0, 128'h0);
        chk("reset out_round", 128'(or0), 128'(0));
        chk("reset out_err", 128'(oe0), 128'(0));
        chk("reset in_ready u8", 128'(ir2), 128'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 round 0
        key_write(4'd0, FIPS_KEY);
        send(0, FIPS_PT, 4'd0);
        wait_drain();
        chk("fips u32", last_od0, FIPS_CT);

        // Back-pressure in DONE
        ordy_cmd = 1'b0;
        send(0, rnd128(), 4'd0);
        n = 0;
        while (!ov0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp reach done", 128'(ov0), 128'(1));
        idata = rnd128(); iround = 4'd1; iv0 = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp in_ready", 128'(ir0), 128'(0));
            chk("bp out_valid", 128'(ov0), 128'(1));
        end
        iv0 = 1'b0;
        ordy_cmd = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 128'(ir0), 128'(1));
        chk("bp release out_valid", 128'(ov0), 128'(0));
        wait_drain();

        // Write/accept collision on slot 3
        key_write(4'd3, {128{1'b1}});
        send(0, 128'h0, 4'd3, 1'b1, 4'd3, 128'h0);
        send(0, 128'h0, 4'd3);
        wait_drain();
        chk("collision second", last_od0, 128'h0);

        // Key rewrite while the block is in RUN
        k = rnd128();
        key_write(4'd5, k);
        send(0, rnd128(), 4'd5);
        key_write(4'd5, ~k);
        wait_drain();

        // Out-of-range round
        send(0, {16{8'hA5}}, 4'd12);
        wait_drain();
        chk("bad idx data", last_od0, {16{8'hA5}});
        chk("bad idx err", 128'(last_oe0), 128'(1));
        chk("bad idx round", 128'(last_or0), 128'(12));

        // Random traffic with random back-pressure and key writes
        bp_mode = 1'b1;
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) key_write(4'($urandom_range(0, 15)), rnd128());
            send(0, rnd128(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), rnd128());
        end
        wait_drain();
        bp_mode = 1'b0;
        ordy_cmd = 1'b1;
        @(posedge clk); #1;

        // Reset during RUN at beat 2
        key_write(4'd0, rnd128() | 128'h1);
        send(0, rnd128(), 4'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post reset in_ready", 128'(ir0), 128'(1));
        repeat (8) begin
            @(posedge clk); #1;
            chk("post reset out_valid", 128'(ov0), 128'(0));
        end
        d = rnd128();
        send(0, d, 4'd0);
        wait_drain();
        chk("cleared slot 0", last_od0, d);

        // FIPS on the 128-bit and 8-bit lane variants
        key_write(4'd0, FIPS_KEY);
        send(1, FIPS_PT, 4'd0);
        wait_drain();
        chk("fips u128", last_od1, FIPS_CT);
        send(2, FIPS_PT, 4'd0);
        wait_drain();
        chk("fips u8", last_od2, FIPS_CT);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
